// File: rtl/pipeline_pkg.sv
// Shared definitions for the DLX pipeline registers: default widths, the bubble
// instruction, the buffered entry layout and a constant-foldable clog2.
package pipeline_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 10;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    // Never returns less than 1 so a 1-entry pointer still gets a real bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Read/write pointer and occupancy tracking for a DEPTH-entry FIFO; pointers wrap
// explicitly so DEPTH does not have to be a power of two.
module sync_fifo_ptr
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        clear_i,
    output logic [clog2(DEPTH)-1:0]     rdPtr_o,
    output logic [clog2(DEPTH+1)-1:0]   count_o,
    output logic [clog2(DEPTH)-1:0]     wrPtr_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Clear wins over everything; a simultaneous push and pop leaves count alone.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (clear_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push_i) wrPtr_d = (wrPtr_q == LAST) ? '0 : wrPtr_q + 1'b1;
            if (pop_i)  rdPtr_d = (rdPtr_q == LAST) ? '0 : rdPtr_q + 1'b1;
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (pop_i && !push_i) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    assign rdPtr_o = rdPtr_q;
    assign wrPtr_o = wrPtr_q;
    assign count_o = count_q;

endmodule

// File: rtl/if_id_skid_latch.sv
// IF/ID pipeline register with a small skid buffer so fetched instructions survive
// decode stalls; flush on taken branch, PC correction and a saturating stall counter.
module if_id_skid_latch
    import pipeline_pkg::*;
#(
    parameter int                 INSTR_W   = pipeline_pkg::INSTR_W,
    parameter int                 PC_W      = pipeline_pkg::PC_W,
    parameter int                 DEPTH     = 2,
    parameter int unsigned        PC_ADJ    = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipeline_pkg::NOP_INSTR),
    parameter int                 CNT_W     = 16
) (
    input  logic                        enable,
    input  logic                        reset,
    input  logic [INSTR_W-1:0]          in_instr,
    input  logic [PC_W-1:0]             in_pc_plus1,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        id_write,
    input  logic                        flush,
    output logic [INSTR_W-1:0]          out_instr,
    output logic [PC_W-1:0]             out_pc,
    output logic                        out_valid,
    output logic [clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int OCC_W = clog2(DEPTH + 1);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } slot_t;

    slot_t            mem_q [DEPTH];
    slot_t            head;
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [OCC_W-1:0] count;
    logic             push, pop;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk_i   (enable),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush),
        .rdPtr_o (rdPtr),
        .count_o (count),
        .wrPtr_o (wrPtr)
    );

    // Readiness comes only from the registered count, so a pop cannot free a slot same-cycle.
    assign in_ready  = (count < OCC_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && id_write && !flush;

    always_ff @(posedge enable) begin
        if (push) begin
            mem_q[wrPtr] <= '{instr: in_instr, pc: in_pc_plus1 - PC_W'(PC_ADJ)};
        end
    end

    assign head      = mem_q[rdPtr];
    assign out_instr = out_valid ? head.instr : NOP_INSTR;
    assign out_pc    = out_valid ? head.pc : '0;
    assign occupancy = count;

    // Stall cycles are counted only while decode holds a real instruction.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (out_valid && !id_write && !flush && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge enable or negedge reset) begin
        if (!reset) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_if_id_skid_latch.sv
// Self-checking bench: a default-parameter instance (DEPTH=2, CNT_W=16) and a
// DEPTH=3, CNT_W=4 instance, each compared against a queue-based reference model.
module tb_if_id_skid_latch;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  pc;
    } modelEntry_t;

    logic clk = 1'b0;
    logic reset;

    logic [31:0] aInstrIn, bInstrIn;
    logic [9:0]  aPc1, bPc1;
    logic        aValidIn, aIdw, aFlush, bValidIn, bIdw, bFlush;
    logic        aReady, aOutValid, bReady, bOutValid;
    logic [31:0] aOutInstr, bOutInstr;
    logic [9:0]  aOutPc, bOutPc;
    logic [1:0]  aOcc, bOcc;
    logic [15:0] aStall;
    logic [3:0]  bStall;

    modelEntry_t qA[$];
    modelEntry_t qB[$];
    int          stA, stB;
    int          testsRun = 0;
    int          testsFailed = 0;

    logic [61:0] obsA;
    logic [49:0] obsB;
    assign obsA = {aOutValid, aOutInstr, aOutPc, aOcc, aReady, aStall};
    assign obsB = {bOutValid, bOutInstr, bOutPc, bOcc, bReady, bStall};

    always #5 clk = ~clk;

    if_id_skid_latch dutA (
        .enable(clk), .reset(reset),
        .in_instr(aInstrIn), .in_pc_plus1(aPc1), .in_valid(aValidIn), .in_ready(aReady),
        .id_write(aIdw), .flush(aFlush),
        .out_instr(aOutInstr), .out_pc(aOutPc), .out_valid(aOutValid),
        .occupancy(aOcc), .stall_cnt(aStall)
    );

    if_id_skid_latch #(.DEPTH(3), .CNT_W(4)) dutB (
        .enable(clk), .reset(reset),
        .in_instr(bInstrIn), .in_pc_plus1(bPc1), .in_valid(bValidIn), .in_ready(bReady),
        .id_write(bIdw), .flush(bFlush),
        .out_instr(bOutInstr), .out_pc(bOutPc), .out_valid(bOutValid),
        .occupancy(bOcc), .stall_cnt(bStall)
    );

    // Expected outputs: head of the queue (or bubble), queue length, room left, stall count.
    function automatic logic [61:0] expA();
        logic v;
        v = (qA.size() != 0);
        return {v, v ? qA[0].instr : 32'h0, v ? qA[0].pc : 10'h0,
                2'(qA.size()), (qA.size() < 2), 16'(stA)};
    endfunction

    function automatic logic [49:0] expB();
        logic v;
        v = (qB.size() != 0);
        return {v, v ? qB[0].instr : 32'h0, v ? qB[0].pc : 10'h0,
                2'(qB.size()), (qB.size() < 3), 4'(stB)};
    endfunction

    // Drive one cycle on instance A, advance the model, and settle 1 time unit after the edge.
    task automatic stepA(input logic v, input logic [31:0] ins, input logic [9:0] p1,
                         input logic idw, input logic fl);
        modelEntry_t e;
        bit canPush, canPop;
        aValidIn = v; aInstrIn = ins; aPc1 = p1; aIdw = idw; aFlush = fl;
        canPush = v && (qA.size() < 2) && !fl;
        canPop  = (qA.size() != 0) && idw && !fl;
        if ((qA.size() != 0) && !idw && !fl && stA < 65535) stA++;
        if (fl) qA.delete();
        else begin
            if (canPop) void'(qA.pop_front());
            if (canPush) begin
                e.instr = ins; e.pc = p1 - 10'd1;
                qA.push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic stepB(input logic v, input logic [31:0] ins, input logic [9:0] p1,
                         input logic idw, input logic fl);
        modelEntry_t e;
        bit canPush, canPop;
        bValidIn = v; bInstrIn = ins; bPc1 = p1; bIdw = idw; bFlush = fl;
        canPush = v && (qB.size() < 3) && !fl;
        canPop  = (qB.size() != 0) && idw && !fl;
        if ((qB.size() != 0) && !idw && !fl && stB < 15) stB++;
        if (fl) qB.delete();
        else begin
            if (canPop) void'(qB.pop_front());
            if (canPush) begin
                e.instr = ins; e.pc = p1 - 10'd1;
                qB.push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        qA.delete(); qB.delete(); stA = 0; stB = 0;
        #1;
    endtask

    task automatic releaseReset();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        if (obsA !== expA()) begin testsFailed++; $display("[TB] FAIL resetA: got %h expected %h", obsA, expA()); end
        testsRun++;
        if (obsB !== expB()) begin testsFailed++; $display("[TB] FAIL resetB: got %h expected %h", obsB, expB()); end
        testsRun++;
        releaseReset();
    endtask

    task automatic test_streaming();
        stepA(1, 32'h20010005, 10'd5, 1, 0);
        if (obsA !== expA()) begin testsFailed++; $display("[TB] FAIL stream_first: got %h expected %h", obsA, expA()); end
        testsRun++;
        stepA(1, 32'h20020007, 10'd6, 1, 0);
        if (obsA !== expA()) begin testsFailed++; $display("[TB] FAIL stream_second: got %h expected %h", obsA, expA()); end
        testsRun++;
        if (aOutPc !== 10'd5 || aOcc !== 2'd1) begin
            testsFailed++;
            $display("[TB] FAIL stream_pc: got pc=%0d occ=%0d expected pc=5 occ=1", aOutPc, aOcc);
        end
        testsRun++;
        stepA(0, 32'h0, 10'd0, 1, 0);
        if (obsA !== expA()) begin testsFailed++; $display("[TB] FAIL stream_drain: got %h expected %h", obsA, expA()); end
        testsRun++;
    endtask

    task automatic test_stall_skid();
        applyReset();
        releaseReset();
        stepA(1, 32'h11110001, 10'd20, 1, 0);
        for (int i = 0; i < 3; i++) begin
            stepA(1, 32'h11110002 + 32'(i), 10'd21 + 10'(i), 0, 0);
            if (obsA !== expA()) begin testsFailed++; $display("[TB] FAIL skid_hold%0d: got %h expected %h", i, obsA, expA()); end
            testsRun++;
        end
        if (aStall !== 16'd3 || aReady !== 1'b0 || aOcc !== 2'd2) begin
            testsFailed++;
            $display("[TB] FAIL skid_full: got stall=%0d ready=%0d occ=%0d expected 3 0 2", aStall, aReady, aOcc);
        end
        testsRun++;
        for (int i = 0; i < 4; i++) begin
            stepA(i < 2, 32'h11110004, 10'd23, 1, 0);
            if (obsA !== expA()) begin testsFailed++; $display("[TB] FAIL skid_release%0d: got %h expected %h", i, obsA, expA()); end
            testsRun++;
        end
    endtask

    task automatic test_flush_priority();
        stepA(1, 32'hAAAA0001, 10'd40, 0, 0);
        stepA(1, 32'hAAAA0002, 10'd41, 0, 0);
        stepA(1, 32'hAAAA0003, 10'd42, 0, 0);
        if (aOcc !== 2'd2) begin testsFailed++; $display("[TB] FAIL flush_prefill: got occ=%0d expected 2", aOcc); end
        testsRun++;
        stepA(1, 32'hAAAA0004, 10'd43, 1, 1);
        if (obsA !== expA()) begin testsFailed++; $display("[TB] FAIL flush_edge: got %h expected %h", obsA, expA()); end
        testsRun++;
        if (aOutValid !== 1'b0 || aOutInstr !== 32'h0 || aOcc !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL flush_bubble: got v=%0d instr=%h occ=%0d expected 0 0 0", aOutValid, aOutInstr, aOcc);
        end
        testsRun++;
    endtask

    task automatic test_pc_boundary();
        stepA(1, 32'hBEEF0000, 10'd0, 0, 0);
        if (aOutPc !== 10'h3FF) begin testsFailed++; $display("[TB] FAIL pc_wrap: got %h expected 3ff", aOutPc); end
        testsRun++;
        stepA(0, 32'h0, 10'd0, 1, 0);
    endtask

    task automatic test_reset_midstream();
        stepA(1, 32'hCCCC0001, 10'd60, 0, 0);
        stepA(1, 32'hCCCC0002, 10'd61, 0, 0);
        if (aOcc !== 2'd2) begin testsFailed++; $display("[TB] FAIL midreset_prefill: got occ=%0d expected 2", aOcc); end
        testsRun++;
        applyReset();
        if (obsA !== {1'b0, 32'h0, 10'h0, 2'd0, 1'b1, 16'd0}) begin
            testsFailed++;
            $display("[TB] FAIL midreset: got %h expected %h", obsA, {1'b0, 32'h0, 10'h0, 2'd0, 1'b1, 16'd0});
        end
        testsRun++;
        releaseReset();
    endtask

    task automatic test_random_a();
        for (int i = 0; i < 150; i++) begin
            stepA($urandom_range(0, 3) != 0, $urandom, 10'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            if (obsA !== expA()) begin testsFailed++; $display("[TB] FAIL randA_%0d: got %h expected %h", i, obsA, expA()); end
            testsRun++;
        end
        aValidIn = 0; aIdw = 1; aFlush = 0;
    endtask

    task automatic test_saturation();
        stepB(1, 32'hDDDD0001, 10'd80, 0, 0);
        for (int i = 0; i < 20; i++) begin
            stepB(0, 32'h0, 10'd0, 0, 0);
            if (obsB !== expB()) begin testsFailed++; $display("[TB] FAIL satB_%0d: got %h expected %h", i, obsB, expB()); end
            testsRun++;
        end
        if (bStall !== 4'd15) begin testsFailed++; $display("[TB] FAIL stall_saturate: got %0d expected 15", bStall); end
        testsRun++;
        stepB(0, 32'h0, 10'd0, 1, 1);
        if (bStall !== 4'd15 || bOcc !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL flush_keeps_stall: got stall=%0d occ=%0d expected 15 0", bStall, bOcc);
        end
        testsRun++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 60; i++) begin
            stepB($urandom_range(0, 3) != 0, $urandom, 10'($urandom), $urandom_range(0, 2) != 0, 0);
            if (obsB !== expB()) begin testsFailed++; $display("[TB] FAIL wrapB_%0d: got %h expected %h", i, obsB, expB()); end
            testsRun++;
            if (bOcc > 2'd3 || bOcc === 2'bxx) begin testsFailed++; $display("[TB] FAIL wrap_occ: got %0d expected <=3", bOcc); end
            testsRun++;
        end
    endtask

    initial begin
        aValidIn = 0; aInstrIn = 0; aPc1 = 0; aIdw = 1; aFlush = 0;
        bValidIn = 0; bInstrIn = 0; bPc1 = 0; bIdw = 1; bFlush = 0;
        stA = 0; stB = 0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush_priority();
        test_pc_boundary();
        test_reset_midstream();
        test_random_a();
        test_saturation();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/if_id_skid_latch.md
Name: if_id_skid_latch

Overview:
- Parametrised IF/ID pipeline register for the MIPS-DLX core, built around a small FIFO (skid buffer) of DEPTH entries.
- Instructions fetched while ID is stalled are kept rather than lost, so fetch and decode are decoupled.
- Supports stall (ID hold), flush on taken branch, a per-entry valid bit, a configurable PC correction, and a saturating stall-cycle counter.
- Sits between the instruction-memory/PC stage and the decode stage; the hazard unit drives id_write and the branch unit drives flush.

Parameters:
- INSTR_W, 32, instruction width.
- PC_W, 10, PC width.
- DEPTH, 2, buffer entries; must be >= 2.
- PC_ADJ, 1, constant subtracted from the incoming PC+1 so that the output PC matches the instruction.
- NOP_INSTR, 0, instruction value driven while no valid entry is present (bubble).
- CNT_W, 16, stall counter width.

Ports:
- enable  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_instr  in  INSTR_W  fetched instruction.
- in_pc_plus1  in  PC_W  PC+1 of the fetched instruction.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer can accept this cycle.
- id_write  in  1  1 = decode consumes the head entry; 0 = hold (stall).
- flush  in  1  taken-branch flush.
- out_instr  out  INSTR_W  head instruction, or NOP_INSTR.
- out_pc  out  PC_W  head PC (already corrected), or 0.
- out_valid  out  1  head entry valid.
- occupancy  out  clog2(DEPTH+1)  number of stored entries.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - count=0, rd_ptr=0, wr_ptr=0, stall_cnt=0.
  - out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries; there is no partial state.
- Push = in_valid && in_ready && !flush. Stores {in_instr, (in_pc_plus1 - PC_ADJ) mod 2^PC_W} at wr_ptr; wr_ptr advances.
- Pop = out_valid && id_write && !flush. rd_ptr advances.
- Pointers wrap explicitly from DEPTH-1 to 0, so DEPTH need not be a power of two.
- count update: push only → +1; pop only → -1; both or neither → unchanged.
- in_ready = (count < DEPTH). It is derived from registered count only; there is no combinational path from id_write.
- Outputs are driven from the head entry (storage[rd_ptr]) and are never combinational from the in_* inputs.
  - Latency: an instruction pushed into an empty buffer at edge k is on out_* immediately after edge k.
- out_valid = (count != 0). While out_valid=0, out_instr=NOP_INSTR and out_pc=0.
- Steady state with id_write=1 and in_valid=1: one instruction per cycle, count stays at 1.
- Full (count==DEPTH):
  - in_ready=0 and fetch must hold its instruction.
  - A pop in that cycle does not allow a same-cycle push; in_ready returns to 1 the following cycle.
- Empty with id_write=1: no pop occurs, outputs stay as the bubble, and there is no underflow.
- Flush (synchronous, on the clock edge): count=0 and rd_ptr=wr_ptr=0; the same-cycle push and pop are suppressed.
  - Flush has priority over push, pop and stall.
  - After the edge: out_valid=0, out_instr=NOP_INSTR, out_pc=0.
- stall_cnt:
  - Increments on an edge when out_valid && !id_write && !flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- PC arithmetic: modulo 2^PC_W. Example with PC_ADJ=1: in_pc_plus1=0 → out_pc=2^PC_W-1.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - Widths INSTR_W and PC_W.
  - NOP_INSTR.
  - A typedef for the entry struct {instr, pc}.
  - A clog2 helper.
- One natural sub-module: sync_fifo_ptr. It provides pointer, wrap and count logic with push, pop and clear, and is reusable by the ID/EX and EX/MEM successors.
- Storage, PC correction and the stall counter stay in the top level.

Test Plan:
- Reset with reset=0 mid-stream while count=2 → immediately: out_valid=0, out_instr=0, out_pc=0, occupancy=0, in_ready=1, stall_cnt=0.
- Streaming: push instrs 0x20010005, 0x20020007 with in_pc_plus1=5 and 6, id_write=1 → outputs on successive cycles with out_pc=4 then 5; occupancy stays at 1.
- Stall/skid: id_write=0 for 3 cycles with in_valid=1, DEPTH=2 → occupancy reaches 2, in_ready=0 and the head is held.
  - Then id_write=1 → both instructions emerge in order with none lost.
  - stall_cnt=3.
- Flush priority: count=2, assert flush together with in_valid=1 and id_write=1 → next cycle occupancy=0, out_valid=0, out_instr=NOP_INSTR; the pushed instruction is dropped.
- Boundary: in_pc_plus1=0 → out_pc=0x3FF. Also, hold id_write=0 for 2^CNT_W+5 cycles with CNT_W=4 → stall_cnt saturates at 15.
- Wrap: DEPTH=3, run 10 push/pop cycles with intermittent stalls → instruction order is preserved across pointer wrap, and occupancy never exceeds 3.
